seg_dynamic: RTL and testbench

Display back-end for the six-digit seven-segment board. It consumes the `data`/`point`/`sign`/`seg_en` bundle produced by the data generator. It converts the binary value to BCD with a sequential double-dabble engine, applies leading-zero blanking, the minus sign and decimal points, and time-multiplexes the six digits. Its `sel`/`seg` outputs feed the 74HC595 shift-register driver.

---
 rtl/seg_dynamic.sv | 153 +++++++++++++++
 tb/tb_seg_dynamic.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/seg_dynamic.sv
// Six-digit seven-segment display back-end: sequential binary-to-BCD conversion,
// leading-zero blanking with sign and decimal points, and time-multiplexed digit scan.
module seg_dynamic #(
  parameter int CNT_MAX = 49999
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [19:0] data,
  input  logic [5:0]  point,
  input  logic        sign,
  input  logic        seg_en,
  output logic [5:0]  sel,
  output logic [7:0]  seg
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t      state;
  logic [19:0] bin_sh;
  logic [23:0] bcd_sh;
  logic [23:0] bcd_adj;
  logic [4:0]  iter;
  logic [5:0]  point_sh;
  logic        sign_sh;

  logic [23:0] disp_bcd;
  logic [5:0]  disp_point;
  logic        disp_sign;

  logic [15:0] cnt;
  logic [2:0]  idx;

  logic [19:0] data_clamped;
  logic [2:0]  hi_digit;
  logic [2:0]  hi_point;
  logic [2:0]  sig_pos;
  logic [7:0]  digit_code [0:7];

  function automatic logic [7:0] seg_lut(input logic [3:0] d);
    case (d)
      4'd0:    seg_lut = 8'hC0;
      4'd1:    seg_lut = 8'hF9;
      4'd2:    seg_lut = 8'hA4;
      4'd3:    seg_lut = 8'hB0;
      4'd4:    seg_lut = 8'h99;
      4'd5:    seg_lut = 8'h92;
      4'd6:    seg_lut = 8'h82;
      4'd7:    seg_lut = 8'hF8;
      4'd8:    seg_lut = 8'h80;
      4'd9:    seg_lut = 8'h90;
      default: seg_lut = 8'hFF;
    endcase
  endfunction

  assign data_clamped = (data > 20'd999999) ? 20'd999999 : data;

  always_comb begin
    bcd_adj = bcd_sh;
    for (int i = 0; i < 6; i++) begin
      if (bcd_sh[4*i +: 4] >= 4'd5)
        bcd_adj[4*i +: 4] = bcd_sh[4*i +: 4] + 4'd3;
    end
  end

  // Free-running double-dabble; the display registers only move in DONE so the scan never sees a partial result.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state      <= IDLE;
      bin_sh     <= '0;
      bcd_sh     <= '0;
      iter       <= '0;
      point_sh   <= '0;
      sign_sh    <= 1'b0;
      disp_bcd   <= '0;
      disp_point <= '0;
      disp_sign  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bin_sh   <= data_clamped;
          point_sh <= point;
          sign_sh  <= sign;
          bcd_sh   <= '0;
          iter     <= '0;
          state    <= SHIFT;
        end
        SHIFT: begin
          {bcd_sh, bin_sh} <= {bcd_adj, bin_sh} << 1;
          iter             <= iter + 5'd1;
          if (iter == 5'd19)
            state <= DONE;
        end
        DONE: begin
          disp_bcd   <= bcd_sh;
          disp_point <= point_sh;
          disp_sign  <= sign_sh;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A set point bit extends the significant field so its digit (and any zeros below it) stays lit.
  always_comb begin
    hi_digit = '0;
    hi_point = '0;
    for (int i = 1; i < 6; i++) begin
      if (disp_bcd[4*i +: 4] != 4'd0)
        hi_digit = 3'(i);
      if (disp_point[i])
        hi_point = 3'(i);
    end
    sig_pos = (hi_digit > hi_point) ? hi_digit : hi_point;

    for (int i = 0; i < 8; i++)
      digit_code[i] = 8'hFF;
    for (int i = 0; i < 6; i++) begin
      if (3'(i) <= sig_pos)
        digit_code[i] = seg_lut(disp_bcd[4*i +: 4]);
      else if (disp_sign && (3'(i) == sig_pos + 3'd1))
        digit_code[i] = 8'hBF;
      if (disp_point[i])
        digit_code[i][7] = 1'b0;
    end
  end

  // sel and seg are registered from the same index so they always switch on the same edge.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt <= '0;
      idx <= '0;
      sel <= '0;
      seg <= 8'hFF;
    end else begin
      if (cnt == 16'(CNT_MAX)) begin
        cnt <= '0;
        idx <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
      end else begin
        cnt <= cnt + 16'd1;
      end

      if (seg_en) begin
        sel <= 6'b000001 << idx;
        seg <= digit_code[idx];
      end else begin
        sel <= '0;
        seg <= 8'hFF;
      end
    end
  end

endmodule

// File: tb/tb_seg_dynamic.sv
// Scoreboard bench for seg_dynamic: stimulus queues the expected scan slots,
// a monitor pops one entry per sel change and checks code, slot width and stability.
module tb_seg_dynamic;

  localparam int CNT_MAX = 9;
  localparam int SLOT    = CNT_MAX + 1;

  logic        sys_clk;
  logic        sys_rst_n;
  logic [19:0] data;
  logic [5:0]  point;
  logic        sign;
  logic        seg_en;
  logic [5:0]  sel;
  logic [7:0]  seg;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      tag;
    logic [5:0] sel;
    logic [7:0] seg;
    int         width;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       cur;
  bit         active = 1'b0;
  int         slot_len;
  bit         slot_glitch;
  logic [5:0] prev_sel = '0;

  seg_dynamic #(.CNT_MAX(CNT_MAX)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .data      (data),
    .point     (point),
    .sign      (sign),
    .seg_en    (seg_en),
    .sel       (sel),
    .seg       (seg)
  );

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  task automatic finishRun();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  endtask

  task automatic abortRun(input string what);
    checks++;
    errors++;
    $display("[TB] FAIL timeout_%s: actual=expired expected=event", what);
    finishRun();
  endtask

  task automatic pushExp(input string tag, input logic [5:0] s, input logic [7:0] g, input int w);
    exp_t e;
    e.tag   = tag;
    e.sel   = s;
    e.seg   = g;
    e.width = w;
    exp_q.push_back(e);
  endtask

  // Returns on the first falling edge at which digit 0's slot has just started.
  task automatic syncDigit0();
    int n = 0;
    while (sel == 6'b000001) begin
      @(negedge sys_clk);
      n++;
      if (n > 200) abortRun("sync_leave");
    end
    n = 0;
    while (sel !== 6'b000001) begin
      @(negedge sys_clk);
      n++;
      if (n > 200) abortRun("sync_enter");
    end
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 || active) begin
      @(negedge sys_clk);
      n++;
      if (n > 400) abortRun("drain");
    end
  endtask

  // exp_vec is {digit5, ..., digit0}; the digit-0 slot in progress at sync is skipped.
  task automatic applyStimulus(input string name, input logic [19:0] d, input logic [5:0] p,
                               input logic s, input logic [47:0] exp_vec);
    data  = d;
    point = p;
    sign  = s;
    repeat (50) @(negedge sys_clk);
    syncDigit0();
    for (int k = 1; k <= 6; k++) begin
      int dg = k % 6;
      pushExp($sformatf("%s_d%0d", name, dg), 6'(1 << dg), exp_vec[8*dg +: 8], SLOT);
    end
    drain();
  endtask

  // Monitor: each change of sel opens a new slot and closes the previous one.
  initial begin
    forever begin
      @(posedge sys_clk);
      #1;
      if (sel !== prev_sel) begin
        if (active) begin
          checkOutput({cur.tag, "_width"}, slot_len, cur.width);
          checkOutput({cur.tag, "_stable"}, 32'(slot_glitch), 32'd0);
        end
        active = 1'b0;
        if (exp_q.size() > 0) begin
          cur = exp_q.pop_front();
          checkOutput({cur.tag, "_sel"}, sel, cur.sel);
          checkOutput({cur.tag, "_seg"}, seg, cur.seg);
          active      = 1'b1;
          slot_len    = 1;
          slot_glitch = 1'b0;
        end
      end else if (active) begin
        slot_len++;
        if (seg !== cur.seg) slot_glitch = 1'b1;
      end
      prev_sel = sel;
    end
  end

  initial begin
    #300000;
    abortRun("watchdog");
  end

  initial begin
    sys_rst_n = 1'b0;
    data      = 20'd123456;
    point     = 6'b000000;
    sign      = 1'b0;
    seg_en    = 1'b1;
    repeat (3) @(negedge sys_clk);
    checkOutput("reset_sel", sel, 6'b000000);
    checkOutput("reset_seg", seg, 8'hFF);

    $display("[TB] releasing reset");
    sys_rst_n = 1'b1;
    pushExp("post_reset_d0", 6'b000001, 8'hC0, SLOT);
    drain();

    applyStimulus("full", 20'd123456, 6'b000000, 1'b0,
                  {8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82});

    $display("[TB] enable test");
    syncDigit0();
    pushExp("disabled",  6'b000000, 8'hFF, 37);
    pushExp("resume_d4", 6'b010000, 8'hA4, SLOT - 1);
    pushExp("resume_d5", 6'b100000, 8'hF9, SLOT);
    pushExp("resume_d0", 6'b000001, 8'h82, SLOT);
    repeat (3) @(negedge sys_clk);
    seg_en = 1'b0;
    repeat (37) @(negedge sys_clk);
    seg_en = 1'b1;
    drain();

    applyStimulus("sign", 20'd42, 6'b000000, 1'b1,
                  {8'hFF, 8'hFF, 8'hFF, 8'hBF, 8'h99, 8'hA4});
    applyStimulus("point", 20'd5, 6'b000100, 1'b0,
                  {8'hFF, 8'hFF, 8'hFF, 8'h40, 8'hC0, 8'h92});
    applyStimulus("clamp", 20'hFFFFF, 6'b000000, 1'b1,
                  {8'h90, 8'h90, 8'h90, 8'h90, 8'h90, 8'h90});
    applyStimulus("zero_neg", 20'd0, 6'b000000, 1'b1,
                  {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hBF, 8'hC0});
    applyStimulus("top_digit", 20'd100000, 6'b000000, 1'b1,
                  {8'hF9, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0});
    applyStimulus("top_point", 20'd3, 6'b100000, 1'b1,
                  {8'h40, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hB0});

    $display("[TB] reset mid-conversion test");
    data  = 20'd7;
    point = 6'b000000;
    sign  = 1'b0;
    repeat (5) @(negedge sys_clk);
    #2;
    sys_rst_n = 1'b0;
    #1;
    checkOutput("async_reset_sel", sel, 6'b000000);
    checkOutput("async_reset_seg", seg, 8'hFF);
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    pushExp("rst_d0_old", 6'b000001, 8'hC0, SLOT);
    pushExp("rst_d1",     6'b000010, 8'hFF, SLOT);
    pushExp("rst_d2",     6'b000100, 8'hFF, SLOT);
    pushExp("rst_d3",     6'b001000, 8'hFF, SLOT);
    pushExp("rst_d4",     6'b010000, 8'hFF, SLOT);
    pushExp("rst_d5",     6'b100000, 8'hFF, SLOT);
    pushExp("rst_d0_new", 6'b000001, 8'hF8, SLOT);
    drain();

    finishRun();
  end

endmodule
